// File: rtl/audio_pkg.sv
// Shared audio definitions: word width, serializer FSM states and the
// level that silence starts on after playback is enabled.
package audio_pkg;

  localparam int AUDIO_WORD_W = 16;

  // First bit of the 1010... silence pattern after enable
  localparam logic SILENCE_INIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/pdm_serializer_if.sv
// Word handshake between the memory reader (master) and the serializer
// (slave). A word transfers on any clock edge where valid && ready.
interface pdm_serializer_if #(
  parameter int WIDTH = audio_pkg::AUDIO_WORD_W
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pdm_serializer.sv
// pdm_serializer: plays 16-bit audio words out MSB-first, one bit per
// bit_tick_i strobe. A one-word holding register feeds the shifter so
// consecutive words play without a gap bit; when no word is waiting the
// pin toggles (1010...) as silence and underrun_o pulses.
// Optional build macro PDM_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter on underrun_cnt_o (cleared only by reset).
module pdm_serializer
  import audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_WORD_W,
  parameter int CNT_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  bit_tick_i,
  pdm_serializer_if.slave       in_if,
  output logic                  pdm_data_o,
  output logic                  pdm_sd_o,
  output logic                  word_done_o,
  output logic                  underrun_o
`ifdef PDM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   shreg_reg;
  logic [WIDTH-1:0]   hold_reg;
  logic               hold_valid_reg;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic               enable_reg;
  logic               pdm_data_reg;
  logic               word_done_reg;
  logic               underrun_reg;
  logic               ready;
`ifdef PDM_UNDERRUN_CNT_EN
  logic [15:0]        underrun_cnt_reg;
`endif

  // Ready depends on registers only, so valid_i never loops back into ready_o
  assign ready       = enable_reg && !hold_valid_reg;
  assign in_if.ready = ready;

  assign pdm_data_o  = pdm_data_reg;
  assign pdm_sd_o    = enable_reg;
  assign word_done_o = word_done_reg;
  assign underrun_o  = underrun_reg;
`ifdef PDM_UNDERRUN_CNT_EN
  assign underrun_cnt_o = underrun_cnt_reg;
`endif

  // Handshake into the holding register, playback FSM and shifter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      bit_cnt_reg    <= '0;
      enable_reg     <= 1'b0;
      pdm_data_reg   <= 1'b0;
      word_done_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
`ifdef PDM_UNDERRUN_CNT_EN
      underrun_cnt_reg <= '0;
`endif
    end else begin
      enable_reg    <= enable_i;
      word_done_reg <= 1'b0;
      underrun_reg  <= 1'b0;

      if (!enable_i) begin
        // Drop everything, including a partial and a held word. The pin
        // parks at the complement of SILENCE_INIT so the first silence
        // tick after re-enable emits SILENCE_INIT.
        state_reg      <= IDLE;
        shreg_reg      <= '0;
        hold_reg       <= '0;
        hold_valid_reg <= 1'b0;
        bit_cnt_reg    <= '0;
        pdm_data_reg   <= ~SILENCE_INIT;
      end else begin
        // Accept only into an empty holder; the FSM consumes only from a
        // full one, so the two never collide on the same edge
        if (in_if.valid && ready) begin
          hold_reg       <= in_if.data;
          hold_valid_reg <= 1'b1;
        end

        case (state_reg)
          IDLE: begin
            state_reg <= WAIT;
          end

          WAIT: begin
            if (bit_tick_i) begin
              pdm_data_reg <= ~pdm_data_reg;
            end
            // Loading does not wait for a tick; shifting starts at the next one
            if (hold_valid_reg) begin
              shreg_reg      <= hold_reg;
              hold_valid_reg <= 1'b0;
              bit_cnt_reg    <= '0;
              state_reg      <= SHIFT;
            end
          end

          SHIFT: begin
            if (bit_tick_i) begin
              pdm_data_reg <= shreg_reg[WIDTH-1];
              shreg_reg    <= shreg_reg << 1;
              bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
              if (bit_cnt_reg == LAST_BIT) begin
                word_done_reg <= 1'b1;
                if (hold_valid_reg) begin
                  // Reload on the same edge as the last bit: no gap bit
                  shreg_reg      <= hold_reg;
                  hold_valid_reg <= 1'b0;
                  bit_cnt_reg    <= '0;
                end else begin
                  state_reg    <= WAIT;
                  underrun_reg <= 1'b1;
`ifdef PDM_UNDERRUN_CNT_EN
                  if (underrun_cnt_reg != 16'hFFFF) begin
                    underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
                  end
`endif
                end
              end
            end
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdm_serializer.sv
// Directed bench for pdm_serializer: single-word playback, gapless
// back-to-back words, holder back-pressure, enable drop, mid-word reset
// and (with PDM_UNDERRUN_CNT_EN) the underrun counter.
module tb_pdm_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        bit_tick_i;
  logic        pdm_data_o;
  logic        pdm_sd_o;
  logic        word_done_o;
  logic        underrun_o;
`ifdef PDM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pdm_serializer_if #(.WIDTH(16)) bus();

  pdm_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .enable_i    (enable_i),
    .bit_tick_i  (bit_tick_i),
    .in_if       (bus),
    .pdm_data_o  (pdm_data_o),
    .pdm_sd_o    (pdm_sd_o),
    .word_done_o (word_done_o),
    .underrun_o  (underrun_o)
`ifdef PDM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    int n;
    n = 0;
    bus.data  = w;
    bus.valid = 1'b1;
    while (!bus.ready && n < 20) begin
      step();
      n++;
    end
    check("push_ready", bus.ready, 1'b1);
    step();
    bus.valid = 1'b0;
    $display("push word %h", w);
  endtask

  // n bit ticks, one idle clock after each; bits collected MSB-first
  task automatic play(input int n, output logic [31:0] bits, output int dones,
                      output int unders, output int last_done);
    bits = '0;
    dones = 0;
    unders = 0;
    last_done = 0;
    for (int i = 1; i <= n; i++) begin
      bit_tick_i = 1'b1;
      step();
      bit_tick_i = 1'b0;
      bits = {bits[30:0], pdm_data_o};
      if (word_done_o) begin
        dones++;
        last_done = i;
      end
      if (underrun_o) unders++;
      step();
      if (word_done_o) dones++;
      if (underrun_o) unders++;
    end
    $display("play %0d ticks: bits=%h done=%0d underrun=%0d", n, bits, dones, unders);
  endtask

  // Assert reset between edges and check outputs clear immediately
  task automatic reset_mid();
    #3;
    reset = 1'b1;
    #1;
    check("rst_mid_pdm", pdm_data_o, 1'b0);
    check("rst_mid_sd", pdm_sd_o, 1'b0);
    check("rst_mid_ready", bus.ready, 1'b0);
    check("rst_mid_done", word_done_o, 1'b0);
    check("rst_mid_under", underrun_o, 1'b0);
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    logic [31:0] b2;
    int d, u, ld, d2, u2, ld2;

    reset      = 1'b1;
    enable_i   = 1'b0;
    bit_tick_i = 1'b0;
    bus.valid  = 1'b0;
    bus.data   = '0;
    #12;
    check("rst_pdm", pdm_data_o, 1'b0);
    check("rst_sd", pdm_sd_o, 1'b0);
    check("rst_ready", bus.ready, 1'b0);
    check("rst_done", word_done_o, 1'b0);
    check("rst_under", underrun_o, 1'b0);
    reset = 1'b0;
    step();
    check("idle_ready", bus.ready, 1'b0);

    // 1: single word then silence
    enable_i = 1'b1;
    step();
    check("en_ready", bus.ready, 1'b1);
    check("en_sd", pdm_sd_o, 1'b1);
    push(16'hA5C3);
    step();
    play(16, b, d, u, ld);
    check("t1_bits", b[15:0], 16'hA5C3);
    check("t1_done_cnt", d, 1);
    check("t1_done_at", ld, 16);
    check("t1_under", u, 1);
    play(2, b, d, u, ld);
    check("t1_silence", b[1:0], 2'b01);
    check("t1_silence_done", d, 0);

    // 2: back-to-back words, no gap
    push(16'hFFFF);
    step();
    push(16'h0000);
    play(31, b, d, u, ld);
    check("t2_under_mid", u, 0);
    check("t2_done_mid", d, 1);
    play(1, b2, d2, u2, ld2);
    check("t2_bits", {b[30:0], b2[0]}, 32'hFFFF0000);
    check("t2_done_last", d2, 1);
    check("t2_under_end", u2, 1);

    // 3: holder full holds off further words
    push(16'hC00C);
    step();
    push(16'h1234);
    bus.valid = 1'b1;
    bus.data  = 16'hDEAD;
    step();
    check("t3_ready_full0", bus.ready, 1'b0);
    bus.data = 16'hBEEF;
    step();
    check("t3_ready_full1", bus.ready, 1'b0);
    bus.valid = 1'b0;
    play(32, b, d, u, ld);
    check("t3_bits", b, 32'hC00C1234);
    check("t3_done", d, 2);
    check("t3_under", u, 1);

    // 4: enable dropped mid-word with a word held, then re-enabled
    push(16'hF0F0);
    step();
    push(16'h0F0F);
    play(7, b, d, u, ld);
    check("t4_partial", b[6:0], 7'h78);
    enable_i = 1'b0;
    step();
    check("t4_drop_pdm", pdm_data_o, 1'b0);
    check("t4_drop_ready", bus.ready, 1'b0);
    check("t4_drop_sd", pdm_sd_o, 1'b0);
    play(3, b, d, u, ld);
    check("t4_idle_bits", b[2:0], 3'b000);
    check("t4_idle_done", d, 0);
    enable_i = 1'b1;
    step();
    push(16'h8001);
    step();
    play(16, b, d, u, ld);
    check("t4_bits", b[15:0], 16'h8001);
    check("t4_done", d, 1);

    // 5: reset mid-word, then normal playback
    push(16'h5555);
    step();
    play(4, b, d, u, ld);
    check("t5_partial", b[3:0], 4'b0101);
    reset_mid();
    step();
    push(16'h5555);
    step();
    play(16, b, d, u, ld);
    check("t5_bits", b[15:0], 16'h5555);
    check("t5_done", d, 1);

`ifdef PDM_UNDERRUN_CNT_EN
    // 6: underrun counter
    reset_mid();
    step();
    check("t6_cnt_start", underrun_cnt_o, 16'd0);
    for (int k = 0; k < 3; k++) begin
      push(16'h00FF);
      step();
      play(16, b, d, u, ld);
      play(2, b, d, u, ld);
    end
    check("t6_cnt3", underrun_cnt_o, 16'd3);
    enable_i = 1'b0;
    step();
    step();
    enable_i = 1'b1;
    step();
    check("t6_cnt_en_toggle", underrun_cnt_o, 16'd3);
    #3;
    reset = 1'b1;
    #1;
    check("t6_cnt_reset", underrun_cnt_o, 16'd0);
    @(posedge clock);
    #3;
    reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
